// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read forwarding and a pending-producer scoreboard.
// After reset a CLEAR sweep zeroes registers 1..N-1; writes and scoreboard sets are accepted only in RUN.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREAD      = 2,
  parameter int BYPASS     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREAD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NREAD*DATA_WIDTH-1:0]   rd_data,
  output logic [NREAD-1:0]              rd_busy,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          sb_set,
  input  logic [ADDR_WIDTH-1:0]         sb_addr,
  output logic                          ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_START = ADDR_WIDTH'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DEPTH-1:0]        sb_q, sb_d;
  logic [DATA_WIDTH-1:0]   rf_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rf_d [DEPTH];
  logic                    active;

  // rst is applied combinationally so outputs are quiet during the reset cycle itself
  assign active = (state_q == RUN) && !rst;
  assign ready  = active;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (rst) begin
      state_d = CLEAR;
      ptr_d   = PTR_START;
    end else if (state_q == CLEAR) begin
      if (ptr_q == PTR_MAX) begin
        state_d = RUN;
      end else begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (rst) begin
      sb_d = '0;
    end else if (state_q == RUN) begin
      // Clear before set so a new producer issued alongside the write wins
      if (wen)    sb_d[waddr]   = 1'b0;
      if (sb_set) sb_d[sb_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    rf_d = rf_q;
    if (!rst) begin
      if (state_q == CLEAR) begin
        rf_d[ptr_q] = '0;
      end else if (wen && (waddr != '0)) begin
        rf_d[waddr] = wdata;
      end
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= PTR_START;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sb_q    <= sb_d;
    end
  end

  // Contents are not reset; the CLEAR sweep is the only zeroing path
  always_ff @(posedge clk) begin
    rf_q <= rf_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) && wen && (waddr == addr) && (addr != '0);
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
      (!active || (addr == '0)) ? '0 : (hit ? wdata : rf_q[addr]);
    assign rd_busy[i] = active && !hit && sb_q[addr];
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width; depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port rd_addr  input  NREAD*ADDR_WIDTH  packed read addresses; port i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port rd_data  output  NREAD*DATA_WIDTH  packed read data, packed like rd_addr.
REQ-009 SHALL have port rd_busy  output  NREAD  scoreboard-pending flag per read port.
REQ-010 SHALL have port wen  input  1  write enable.
REQ-011 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-012 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port sb_set  input  1  marks register sb_addr as having a pending producer.
REQ-014 SHALL have port sb_addr  input  ADDR_WIDTH  scoreboard set address.
REQ-015 SHALL have port ready  output  1  high when the block is in RUN state.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN.
REQ-017 CLEAR: an internal pointer ptr SHALL write 0 to rf[ptr] each cycle, starting at 1 and ending at 2^ADDR_WIDTH-1.
REQ-018 SHALL move CLEAR->RUN on the edge that writes ptr = 2^ADDR_WIDTH-1.
REQ-019 ready SHALL therefore rise exactly 2^ADDR_WIDTH-1 cycles after the first cycle with rst low.
REQ-020 In CLEAR, wen and sb_set SHALL be ignored, rd_data SHALL read all-zero, and rd_busy SHALL read all-zero.
REQ-021 Register 0 SHALL always read 0; writes and sb_set to address 0 SHALL be ignored.
REQ-022 In RUN, wen=1 with waddr!=0 SHALL store wdata into rf[waddr] at the clock edge.
REQ-023 Reads SHALL be combinational (zero latency): rd_data_i = rf[rd_addr_i].
REQ-024 With BYPASS=1, if wen=1, waddr=rd_addr_i and rd_addr_i!=0, rd_data_i SHALL equal wdata in the same cycle.
REQ-025 With BYPASS=0, a read of the address being written SHALL return the old value until the next cycle.
REQ-026 Scoreboard: one bit per register, sb[0] hardwired 0.
REQ-027 In RUN, sb_set=1 SHALL set sb[sb_addr].
REQ-028 In RUN, wen=1 SHALL clear sb[waddr].
REQ-029 If sb_set and wen target the same nonzero address in one cycle, set SHALL win: the bit ends 1 because a new producer was issued.
REQ-030 rd_busy_i SHALL be sb[rd_addr_i], except it SHALL be 0 when BYPASS=1 and the same-cycle write matches per REQ-024.
REQ-031 Several read ports with the same address SHALL return identical data and busy.
REQ-032 ptr SHALL be exactly ADDR_WIDTH bits; no wrap occurs because the FSM leaves CLEAR at the maximum value.

Reset
REQ-033 While rst=1: state=CLEAR, ptr=1, all sb bits=0, ready=0, rd_data=0, rd_busy=0.
REQ-034 Register contents SHALL be zeroed only by the CLEAR sweep, not by rst directly.
REQ-035 rst asserted in RUN or mid-CLEAR SHALL abort the current state, restart the sweep at ptr=1, and discard any same-cycle write or sb_set.

Verification
REQ-036 Defaults. rst high 2 cycles then low -> ready=0 for 31 cycles and 1 on the 32nd; then all 32 registers read 0 on both ports.
REQ-037 Write and bypass. In RUN, wen=1, waddr=5, wdata=0xDEADBEEF, rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF that cycle (BYPASS=1); with BYPASS=0, old value 0 that cycle and 0xDEADBEEF next cycle.
REQ-038 x0. wen=1, waddr=0, wdata=0x1234 and sb_set=1, sb_addr=0 -> reads of address 0 return 0 and rd_busy=0.
REQ-039 Scoreboard. sb_set at addr 7 -> rd_busy=1 for addr 7 from the next cycle; wen to 7 -> rd_busy=0 in that cycle (bypass) and after it. Simultaneous sb_set and wen on 7 -> rd_busy=1 afterwards and rf[7]=wdata.
REQ-040 Reset mid-operation. Write 0xA5 to reg 3, set sb[9], pulse rst in RUN -> ready=0, sb clear, ready returns after 31 cycles, reg 3 reads 0.
REQ-041 Blocked in CLEAR. wen=1, waddr=31, wdata=0xFF at cycle 10 of the sweep -> after ready, reg 31 reads 0.
